// File: rtl/hsmultacc_pipe_n.sv
// hsmultacc_pipe_n -- pipelined multiply-accumulate with a fixed latency.
//
// A slot presented with IN_VALID=1 at edge t updates PROD and pulses
// OUT_VALID at edge t+STAGES. Each slot carries its own signed/unsigned
// mode and accumulate select. In accumulate mode the addend is the PROD
// register itself, read at the final stage, so back-to-back accumulate
// slots need no bubbles. OVF is sticky until CLR or reset.
//
// Optional build macro HSMULTACC_SAT_EN: when defined, an overflowing sum
// clamps PROD to the representable limit of the slot's mode instead of
// wrapping modulo 2^P. When undefined no clamp logic exists.
//
// STAGES must lie in 2..5. Data registers are not reset; only the valid
// chain, PROD, OUT_VALID and OVF are.

module hsmultacc_pipe_n #(
  parameter int AA     = 6,
  parameter int BB     = 6,
  parameter int CC     = 12,
  parameter int P      = 12,
  parameter int STAGES = 3
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          IN_VALID,
  input  logic [AA-1:0] A,
  input  logic [BB-1:0] B,
  input  logic [CC-1:0] C,
  input  logic          MODE_SIGNED,
  input  logic          ACC_EN,
  input  logic          CLR,
  output logic          OUT_VALID,
  output logic [P-1:0]  PROD,
  output logic          OVF
);

  // Full product width, and the final-sum width: wide enough that the
  // sum of any extended product and any extended addend is exact.
  localparam int MW    = AA + BB;
  localparam int XW    = (MW > CC) ? MW : CC;
  localparam int SW    = ((XW > P) ? XW : P) + 1;
  // Register levels between stage 1 and the PROD register.
  localparam int DEPTH = STAGES - 1;

  // ---------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------

  // Product of A and B under the slot's mode. Both operands are extended
  // to MW bits, so the low MW bits of the product are exact in either mode.
  function automatic logic [MW-1:0] mul_op(input logic [AA-1:0] a,
                                           input logic [BB-1:0] b,
                                           input logic          sgn);
    logic signed [MW-1:0] ae;
    logic signed [MW-1:0] be;
    ae = {{BB{sgn & a[AA-1]}}, a};
    be = {{AA{sgn & b[BB-1]}}, b};
    return ae * be;
  endfunction

  // Extend the registered product to the sum width.
  function automatic logic signed [SW-1:0] ext_mul(input logic [MW-1:0] m,
                                                   input logic          sgn);
    return {{(SW-MW){sgn & m[MW-1]}}, m};
  endfunction

  // Extend the external addend to the sum width.
  function automatic logic signed [SW-1:0] ext_c(input logic [CC-1:0] c,
                                                 input logic          sgn);
    return {{(SW-CC){sgn & c[CC-1]}}, c};
  endfunction

  // Extend the accumulator value to the sum width.
  function automatic logic signed [SW-1:0] ext_acc(input logic [P-1:0] r,
                                                   input logic         sgn);
    return {{(SW-P){sgn & r[P-1]}}, r};
  endfunction

  // True when the exact sum does not fit in P bits under the slot's mode.
  // Unsigned: any bit above P-1 is set. Signed: bits SW-1..P-1 disagree.
  function automatic logic ovf_chk(input logic signed [SW-1:0] s,
                                   input logic                 sgn);
    logic [SW-P:0] top;
    top = s[SW-1:P-1];
    if (sgn) begin
      return !((&top) || !(|top));
    end
    return |top[SW-P:1];
  endfunction

`ifdef HSMULTACC_SAT_EN
  // Clamp an overflowing sum to the nearest representable value.
  function automatic logic [P-1:0] sat_res(input logic signed [SW-1:0] s,
                                           input logic                 sgn,
                                           input logic                 ovf);
    if (!ovf) begin
      return s[P-1:0];
    end
    if (!sgn) begin
      return '1;
    end
    if (s[SW-1]) begin
      return {1'b1, {(P-1){1'b0}}};
    end
    return {1'b0, {(P-1){1'b1}}};
  endfunction
`endif

  // ---------------------------------------------------------------------
  // Pipeline storage
  // ---------------------------------------------------------------------

  // Stage 1: captured operands and slot controls.
  logic [AA-1:0] a_p1;
  logic [BB-1:0] b_p1;
  logic [CC-1:0] c_p1;
  logic          sgn_p1;
  logic          acc_p1;
  logic          vld_p1;

  // Stages 2..STAGES: element k is the register level entered k+1 edges
  // after stage 1. The last element feeds the final add.
  logic [MW-1:0]    mul_pn [DEPTH];
  logic [CC-1:0]    c_pn   [DEPTH];
  logic [DEPTH-1:0] sgn_pn;
  logic [DEPTH-1:0] acc_pn;
  logic [DEPTH-1:0] vld_pn;

  // Final-stage combinational results.
  logic signed [SW-1:0] prod_x;
  logic signed [SW-1:0] add_x;
  logic signed [SW-1:0] sum_x;
  logic                 ovf_x;
  logic [P-1:0]         res_x;

  // ---- stage 1 -> stage 2..STAGES : operand capture and product pipe ----
  // Datapath registers: no reset, validity is tracked by the vld chain.
  always_ff @(posedge CLK) begin
    a_p1      <= A;
    b_p1      <= B;
    c_p1      <= C;
    sgn_p1    <= MODE_SIGNED;
    acc_p1    <= ACC_EN;
    mul_pn[0] <= mul_op(a_p1, b_p1, sgn_p1);
    c_pn[0]   <= c_p1;
    sgn_pn[0] <= sgn_p1;
    acc_pn[0] <= acc_p1;
    for (int k = 1; k < DEPTH; k++) begin
      mul_pn[k] <= mul_pn[k-1];
      c_pn[k]   <= c_pn[k-1];
      sgn_pn[k] <= sgn_pn[k-1];
      acc_pn[k] <= acc_pn[k-1];
    end
  end

  // ---- stage STAGES : extend, add against C or the accumulator, check ----
  // Final add and overflow detection for the slot leaving the pipe.
  always_comb begin
    prod_x = ext_mul(mul_pn[DEPTH-1], sgn_pn[DEPTH-1]);
    if (acc_pn[DEPTH-1]) begin
      add_x = ext_acc(PROD, sgn_pn[DEPTH-1]);
    end else begin
      add_x = ext_c(c_pn[DEPTH-1], sgn_pn[DEPTH-1]);
    end
    sum_x = prod_x + add_x;
    ovf_x = ovf_chk(sum_x, sgn_pn[DEPTH-1]);
`ifdef HSMULTACC_SAT_EN
    res_x = sat_res(sum_x, sgn_pn[DEPTH-1], ovf_x);
`else
    res_x = sum_x[P-1:0];
`endif
  end

  // Valid chain and result registers; CLR kills every in-flight slot and
  // takes priority over a slot arriving or completing on the same edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_p1    <= 1'b0;
      vld_pn    <= '0;
      OUT_VALID <= 1'b0;
      PROD      <= '0;
      OVF       <= 1'b0;
    end else if (CLR) begin
      vld_p1    <= 1'b0;
      vld_pn    <= '0;
      OUT_VALID <= 1'b0;
      PROD      <= '0;
      OVF       <= 1'b0;
    end else begin
      vld_p1    <= IN_VALID;
      vld_pn[0] <= vld_p1;
      for (int k = 1; k < DEPTH; k++) begin
        vld_pn[k] <= vld_pn[k-1];
      end
      OUT_VALID <= vld_pn[DEPTH-1];
      if (vld_pn[DEPTH-1]) begin
        PROD <= res_x;
        OVF  <= OVF | ovf_x;
      end
    end
  end

endmodule
